// File: rtl/store_capture_fifo.sv
// store_capture_fifo: captures in-window core stores into a sequence-tagged FWFT FIFO with overflow accounting
module store_capture_fifo #(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF,
  parameter int          SEQ_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite_in,
  input  logic [31:0]              dataadr_in,
  input  logic [31:0]              writedata_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [SEQ_W-1:0] r_tag  [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [SEQ_W-1:0] r_seq;
  logic             r_overflow;
  logic [15:0]      r_drop;

  logic [32:0] w_lo_diff;
  logic [32:0] w_hi_diff;
  logic        w_qual;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [15:0] w_drop_inc;

  // Window check via 33-bit borrow so a full-range window needs no constant comparisons
  always_comb begin
    w_lo_diff  = {1'b0, dataadr_in} - {1'b0, ADDR_LO};
    w_hi_diff  = {1'b0, ADDR_HI} - {1'b0, dataadr_in};
    w_qual     = memwrite_in && !w_lo_diff[32] && !w_hi_diff[32];
    w_full     = r_count == CW'(DEPTH);
    w_empty    = r_count == '0;
    w_pop      = !w_empty && out_ready;
    w_push     = w_qual && (!w_full || w_pop);
    w_drop     = w_qual && w_full && !w_pop;
    w_drop_inc = (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
  end

  // Entry storage; contents are only visible through the empty-gated head outputs
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr] <= dataadr_in;
      r_data[r_wr] <= writedata_in;
      r_tag[r_wr]  <= r_seq;
    end
  end

  // Pointers, occupancy, sequence counter and overflow accounting; a same-cycle drop beats clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_push) begin
        r_wr  <= r_wr + AW'(1);
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_push != w_pop)
        r_count <= w_push ? r_count + CW'(1) : r_count - CW'(1);
      r_overflow <= w_drop || (r_overflow && !clear_overflow);
      r_drop     <= w_drop ? (clear_overflow ? 16'd1 : w_drop_inc) : (clear_overflow ? 16'd0 : r_drop);
    end
  end

  // Head entry falls through; outputs read zero while empty
  always_comb begin
    out_valid  = !w_empty;
    out_addr   = w_empty ? 32'd0 : r_addr[r_rd];
    out_data   = w_empty ? 32'd0 : r_data[r_rd];
    out_seq    = w_empty ? '0 : r_tag[r_rd];
    count      = r_count;
    full       = w_full;
    empty      = w_empty;
    overflow   = r_overflow;
    drop_count = r_drop;
  end
endmodule
